ahbl_to_apb: RTL and testbench
==============================

AHBL_TO_APB -- requirements
Module: ahbl_to_apb

Interface
REQ-001 The block SHALL have parameter W_HADDR, default 32, meaning AHB-Lite address width.
REQ-002 The block SHALL have parameter W_PADDR, default 16, meaning APB address width; paddr = haddr[W_PADDR-1:0].
REQ-003 The block SHALL have parameter W_DATA, default 32, meaning AHB and APB data width.
REQ-004 The block SHALL have these ports, one per line (name, direction, width, meaning):
  clk  input  1  single clock for all logic
  rst_n  input  1  reset, synchronous, active-low
  ahbls_hready  input  1  global bus hready
  ahbls_hready_resp  output  1  slave hready response
  ahbls_hresp  output  1  error response
  ahbls_haddr  input  W_HADDR  address
  ahbls_hwrite  input  1  write
  ahbls_htrans  input  2  transfer type
  ahbls_hsize  input  3  transfer size
  ahbls_hburst  input  3  ignored
  ahbls_hprot  input  4  ignored
  ahbls_hmastlock  input  1  ignored
  ahbls_hwdata  input  W_DATA  write data
  ahbls_hrdata  output  W_DATA  read data
  apbm_paddr  output  W_PADDR  APB address
  apbm_psel  output  1  select
  apbm_penable  output  1  enable
  apbm_pwrite  output  1  write
  apbm_pwdata  output  W_DATA  write data
  apbm_prdata  input  W_DATA  read data
  apbm_pready  input  1  ready
  apbm_pslverr  input  1  slave error
REQ-005 Reset SHALL be synchronous and active-low on rst_n, sampled on rising clk; clk is the only clock.

Function
REQ-006 An address phase SHALL be accepted when ahbls_hready && ahbls_htrans[1]; paddr and pwrite are registered at that edge.
REQ-007 FSM states SHALL be: IDLE, SETUP, ACCESS, DONE, ERR1, ERR2.
REQ-008 Acceptance from IDLE or DONE SHALL go to SETUP; with no acceptance, IDLE/DONE SHALL go to IDLE.
REQ-009 SETUP SHALL drive psel=1, penable=0, hready_resp=0, then go to ACCESS unconditionally.
REQ-010 ACCESS SHALL drive psel=1, penable=1, hready_resp=0; it holds while pready=0.
REQ-011 ACCESS with pready=1, pslverr=0 SHALL go to DONE; for reads, hrdata SHALL load prdata at that edge.
REQ-012 ACCESS with pready=1, pslverr=1 SHALL go to ERR1; hrdata is unchanged.
REQ-013 ERR1 SHALL drive hready_resp=0, hresp=1, then go to ERR2.
REQ-014 ERR2 SHALL drive hready_resp=1, hresp=1, then go to IDLE; an acceptance in ERR2 is ignored, because an AHB master cancels after an error.
REQ-015 IDLE and DONE SHALL drive hready_resp=1, hresp=0, psel=0, penable=0.
REQ-016 apbm_pwdata SHALL equal ahbls_hwdata combinationally; AHB data-phase stability gives APB stability.
REQ-017 paddr and pwrite SHALL hold stable from SETUP through the last ACCESS cycle.
REQ-018 Minimum latency SHALL be: address phase at cycle A, SETUP at A+1, ACCESS at A+2, DONE (hready_resp=1) at A+3.
REQ-019 Back-to-back transfers SHALL be accepted in DONE with no idle cycle.
REQ-020 htrans=IDLE or BUSY, or hready=0, SHALL never start an APB access.

Reset
REQ-021 While rst_n=0 at a clk edge, the state SHALL become IDLE, and the outputs SHALL become: hready_resp=1, hresp=0, psel=0, penable=0, pwrite=0, paddr=0, hrdata=0.
REQ-022 Reset asserted mid-transfer (SETUP, ACCESS, ERR1 or ERR2) SHALL abandon the transfer at that edge, with no further APB cycle.

Configuration
REQ-023 Macro AHBL_TO_APB_SIZE_CHECK_EN, when defined, SHALL make an accepted transfer with hsize != $clog2(W_DATA/8) go directly to ERR1, with psel never asserted.
REQ-024 Without AHBL_TO_APB_SIZE_CHECK_EN, all sizes SHALL be forwarded unchanged, including the address LSBs.

Verification
REQ-025 The bench SHALL cover: read at haddr 0x0000_1234, prdata=0xCAFEF00D, pready=1 -> psel at A+1, penable at A+2, hready_resp=1 and hrdata=0xCAFEF00D at A+3, paddr=0x1234.
REQ-026 The bench SHALL cover: write of 0x12345678 with pready low for 3 ACCESS cycles -> penable high for 4 cycles, pwdata/paddr stable, hready_resp=1 exactly one cycle after pready.
REQ-027 The bench SHALL cover: read with pslverr=1 -> ERR1 (hready_resp=0, hresp=1), then ERR2 (hready_resp=1, hresp=1), then IDLE; a new address in ERR2 causes no psel.
REQ-028 The bench SHALL cover: back-to-back write then read, pready=1 -> second SETUP immediately after first DONE, 3-cycle data phase each.
REQ-029 The bench SHALL cover: rst_n=0 during ACCESS -> next edge psel=0, penable=0, hready_resp=1, hrdata=0.
REQ-030 The bench SHALL cover: with AHBL_TO_APB_SIZE_CHECK_EN, a byte write (hsize=0) -> two-cycle error response, psel stays 0; without the macro -> normal APB write.

Source files
------------

// File: rtl/ahbl_to_apb.sv
// AHB-Lite slave to APB master bridge.
// One APB transfer per accepted AHB address phase; pslverr is returned as a
// two-cycle AHB error response. Optional build macro AHBL_TO_APB_SIZE_CHECK_EN
// rejects transfers whose hsize is not the full data-bus width.
module ahbl_to_apb #(
  parameter int W_HADDR = 32,
  parameter int W_PADDR = 16,
  parameter int W_DATA  = 32
) (
  input  logic               clk,
  input  logic               rst_n,

  input  logic               ahbls_hready,
  output logic               ahbls_hready_resp,
  output logic               ahbls_hresp,
  input  logic [W_HADDR-1:0] ahbls_haddr,
  input  logic               ahbls_hwrite,
  input  logic [1:0]         ahbls_htrans,
  input  logic [2:0]         ahbls_hsize,
  input  logic [2:0]         ahbls_hburst,
  input  logic [3:0]         ahbls_hprot,
  input  logic               ahbls_hmastlock,
  input  logic [W_DATA-1:0]  ahbls_hwdata,
  output logic [W_DATA-1:0]  ahbls_hrdata,

  output logic [W_PADDR-1:0] apbm_paddr,
  output logic               apbm_psel,
  output logic               apbm_penable,
  output logic               apbm_pwrite,
  output logic [W_DATA-1:0]  apbm_pwdata,
  input  logic [W_DATA-1:0]  apbm_prdata,
  input  logic               apbm_pready,
  input  logic               apbm_pslverr
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE,
    ERR1,
    ERR2
  } state_t;

  state_t              state_q, state_d;
  logic [W_PADDR-1:0]  paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [W_DATA-1:0]   hrdata_q, hrdata_d;

  logic                accept;
  logic                size_bad;

  // Burst, protection and lock attributes carry no meaning for APB.
  logic                unused_attr;
  assign unused_attr = ^{ahbls_hburst, ahbls_hprot, ahbls_hmastlock,
                         ahbls_haddr, ahbls_hsize};

  assign accept = ahbls_hready && ahbls_htrans[1];

`ifdef AHBL_TO_APB_SIZE_CHECK_EN
  localparam logic [2:0] SIZE_NATIVE = 3'($clog2(W_DATA / 8));
  assign size_bad = (ahbls_hsize != SIZE_NATIVE);
`else
  assign size_bad = 1'b0;
`endif

  // Write data passes straight through; the AHB data phase holds it stable.
  assign apbm_pwdata  = ahbls_hwdata;
  assign apbm_paddr   = paddr_q;
  assign apbm_pwrite  = pwrite_q;
  assign ahbls_hrdata = hrdata_q;

  // State, captured address phase and read data registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      hrdata_q <= hrdata_d;
    end
  end

  // Next-state logic and address/read-data capture.
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    hrdata_d = hrdata_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          paddr_d  = ahbls_haddr[W_PADDR-1:0];
          pwrite_d = ahbls_hwrite;
          state_d  = size_bad ? ERR1 : SETUP;
        end else begin
          state_d  = IDLE;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (apbm_pready) begin
          if (apbm_pslverr) begin
            state_d = ERR1;
          end else begin
            state_d = DONE;
            if (!pwrite_q) hrdata_d = apbm_prdata;
          end
        end
      end
      ERR1: state_d = ERR2;
      // A master cancels its next transfer after an error, so ignore it.
      ERR2: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus handshake outputs decoded from the current state.
  always_comb begin
    apbm_psel         = 1'b0;
    apbm_penable      = 1'b0;
    ahbls_hready_resp = 1'b1;
    ahbls_hresp       = 1'b0;
    case (state_q)
      SETUP: begin
        apbm_psel         = 1'b1;
        ahbls_hready_resp = 1'b0;
      end
      ACCESS: begin
        apbm_psel         = 1'b1;
        apbm_penable      = 1'b1;
        ahbls_hready_resp = 1'b0;
      end
      ERR1: begin
        ahbls_hready_resp = 1'b0;
        ahbls_hresp       = 1'b1;
      end
      ERR2: begin
        ahbls_hresp       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahbl_to_apb.sv
// Directed self-checking bench for ahbl_to_apb.
module tb_ahbl_to_apb;

  logic        clk;
  logic        rst_n;
  logic        ahbls_hready;
  logic        ahbls_hready_resp;
  logic        ahbls_hresp;
  logic [31:0] ahbls_haddr;
  logic        ahbls_hwrite;
  logic [1:0]  ahbls_htrans;
  logic [2:0]  ahbls_hsize;
  logic [2:0]  ahbls_hburst;
  logic [3:0]  ahbls_hprot;
  logic        ahbls_hmastlock;
  logic [31:0] ahbls_hwdata;
  logic [31:0] ahbls_hrdata;
  logic [15:0] apbm_paddr;
  logic        apbm_psel;
  logic        apbm_penable;
  logic        apbm_pwrite;
  logic [31:0] apbm_pwdata;
  logic [31:0] apbm_prdata;
  logic        apbm_pready;
  logic        apbm_pslverr;

  logic        hready_low;
  int          checks = 0;
  int          passes = 0;

  // Global hready follows the bridge's response unless forced low.
  assign ahbls_hready = hready_low ? 1'b0 : ahbls_hready_resp;

  ahbl_to_apb #(
    .W_HADDR(32),
    .W_PADDR(16),
    .W_DATA (32)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ahbls_hready     (ahbls_hready),
    .ahbls_hready_resp(ahbls_hready_resp),
    .ahbls_hresp      (ahbls_hresp),
    .ahbls_haddr      (ahbls_haddr),
    .ahbls_hwrite     (ahbls_hwrite),
    .ahbls_htrans     (ahbls_htrans),
    .ahbls_hsize      (ahbls_hsize),
    .ahbls_hburst     (ahbls_hburst),
    .ahbls_hprot      (ahbls_hprot),
    .ahbls_hmastlock  (ahbls_hmastlock),
    .ahbls_hwdata     (ahbls_hwdata),
    .ahbls_hrdata     (ahbls_hrdata),
    .apbm_paddr       (apbm_paddr),
    .apbm_psel        (apbm_psel),
    .apbm_penable     (apbm_penable),
    .apbm_pwrite      (apbm_pwrite),
    .apbm_pwdata      (apbm_pwdata),
    .apbm_prdata      (apbm_prdata),
    .apbm_pready      (apbm_pready),
    .apbm_pslverr     (apbm_pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Outputs are sampled on the falling edge.
  task automatic sample();
    @(negedge clk);
  endtask

  task automatic addr_phase(input logic [31:0] addr, input logic wr);
    ahbls_htrans = 2'b10;
    ahbls_haddr  = addr;
    ahbls_hwrite = wr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    sample();
    checks++; if (ahbls_hready_resp !== 1'b1) $display("FAIL rst_hready_resp: got %b want 1", ahbls_hready_resp); else passes++;
    checks++; if (ahbls_hresp !== 1'b0) $display("FAIL rst_hresp: got %b want 0", ahbls_hresp); else passes++;
    checks++; if (apbm_psel !== 1'b0 || apbm_penable !== 1'b0) $display("FAIL rst_psel_penable: got %b%b want 00", apbm_psel, apbm_penable); else passes++;
    checks++; if (apbm_pwrite !== 1'b0) $display("FAIL rst_pwrite: got %b want 0", apbm_pwrite); else passes++;
    checks++; if (apbm_paddr !== 16'h0000) $display("FAIL rst_paddr: got %h want 0000", apbm_paddr); else passes++;
    checks++; if (ahbls_hrdata !== 32'h0) $display("FAIL rst_hrdata: got %h want 00000000", ahbls_hrdata); else passes++;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_read();
    step();
    addr_phase(32'h0000_1234, 1'b0);
    apbm_pready  = 1'b1;
    apbm_pslverr = 1'b0;
    apbm_prdata  = 32'hCAFE_F00D;
    sample();
    checks++; if (apbm_psel !== 1'b0) $display("FAIL read_A_psel: got %b want 0", apbm_psel); else passes++;
    step();
    ahbls_htrans = 2'b00;
    sample();
    checks++; if (apbm_psel !== 1'b1 || apbm_penable !== 1'b0) $display("FAIL read_A1_setup: got psel=%b penable=%b want 1 0", apbm_psel, apbm_penable); else passes++;
    checks++; if (ahbls_hready_resp !== 1'b0) $display("FAIL read_A1_hready: got %b want 0", ahbls_hready_resp); else passes++;
    checks++; if (apbm_paddr !== 16'h1234 || apbm_pwrite !== 1'b0) $display("FAIL read_A1_addr: got %h/%b want 1234/0", apbm_paddr, apbm_pwrite); else passes++;
    step();
    sample();
    checks++; if (apbm_psel !== 1'b1 || apbm_penable !== 1'b1 || ahbls_hready_resp !== 1'b0) $display("FAIL read_A2_access: got psel=%b penable=%b hready=%b want 1 1 0", apbm_psel, apbm_penable, ahbls_hready_resp); else passes++;
    step();
    sample();
    checks++; if (ahbls_hready_resp !== 1'b1 || ahbls_hresp !== 1'b0) $display("FAIL read_A3_done: got hready=%b hresp=%b want 1 0", ahbls_hready_resp, ahbls_hresp); else passes++;
    checks++; if (ahbls_hrdata !== 32'hCAFE_F00D) $display("FAIL read_A3_hrdata: got %h want cafef00d", ahbls_hrdata); else passes++;
    checks++; if (apbm_psel !== 1'b0 || apbm_penable !== 1'b0) $display("FAIL read_A3_idle_apb: got %b%b want 00", apbm_psel, apbm_penable); else passes++;
  endtask

  task automatic test_write_wait();
    int en_cycles;
    en_cycles = 0;
    step();
    addr_phase(32'h0000_4A8C, 1'b1);
    apbm_pready = 1'b0;
    apbm_prdata = 32'hDEAD_BEEF;
    step();
    ahbls_htrans = 2'b00;
    ahbls_hwdata = 32'h1234_5678;
    sample();
    checks++; if (apbm_psel !== 1'b1 || apbm_penable !== 1'b0 || apbm_pwrite !== 1'b1) $display("FAIL wr_setup: got psel=%b penable=%b pwrite=%b want 1 0 1", apbm_psel, apbm_penable, apbm_pwrite); else passes++;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 3) apbm_pready = 1'b1;
      sample();
      if (apbm_penable === 1'b1) en_cycles++;
      checks++; if (ahbls_hready_resp !== 1'b0) $display("FAIL wr_access_hready[%0d]: got %b want 0", i, ahbls_hready_resp); else passes++;
      checks++; if (apbm_paddr !== 16'h4A8C || apbm_pwdata !== 32'h1234_5678 || apbm_pwrite !== 1'b1) $display("FAIL wr_access_stable[%0d]: got %h/%h/%b want 4a8c/12345678/1", i, apbm_paddr, apbm_pwdata, apbm_pwrite); else passes++;
    end
    checks++; if (en_cycles != 4) $display("FAIL wr_penable_cycles: got %0d want 4", en_cycles); else passes++;
    step();
    sample();
    checks++; if (ahbls_hready_resp !== 1'b1 || apbm_penable !== 1'b0 || apbm_psel !== 1'b0) $display("FAIL wr_done: got hready=%b penable=%b psel=%b want 1 0 0", ahbls_hready_resp, apbm_penable, apbm_psel); else passes++;
    checks++; if (ahbls_hrdata !== 32'hCAFE_F00D) $display("FAIL wr_hrdata_kept: got %h want cafef00d", ahbls_hrdata); else passes++;
  endtask

  task automatic test_error();
    step();
    addr_phase(32'h0000_0010, 1'b0);
    apbm_pready  = 1'b1;
    apbm_pslverr = 1'b1;
    apbm_prdata  = 32'h1111_1111;
    step();
    ahbls_htrans = 2'b00;
    step();
    step();
    sample();
    checks++; if (ahbls_hready_resp !== 1'b0 || ahbls_hresp !== 1'b1) $display("FAIL err1: got hready=%b hresp=%b want 0 1", ahbls_hready_resp, ahbls_hresp); else passes++;
    checks++; if (ahbls_hrdata !== 32'hCAFE_F00D) $display("FAIL err_hrdata_kept: got %h want cafef00d", ahbls_hrdata); else passes++;
    checks++; if (apbm_psel !== 1'b0) $display("FAIL err1_psel: got %b want 0", apbm_psel); else passes++;
    step();
    apbm_pslverr = 1'b0;
    addr_phase(32'h0000_0020, 1'b0);
    sample();
    checks++; if (ahbls_hready_resp !== 1'b1 || ahbls_hresp !== 1'b1) $display("FAIL err2: got hready=%b hresp=%b want 1 1", ahbls_hready_resp, ahbls_hresp); else passes++;
    step();
    ahbls_htrans = 2'b00;
    sample();
    checks++; if (apbm_psel !== 1'b0 || ahbls_hresp !== 1'b0 || ahbls_hready_resp !== 1'b1) $display("FAIL err_after_idle: got psel=%b hresp=%b hready=%b want 0 0 1", apbm_psel, ahbls_hresp, ahbls_hready_resp); else passes++;
    checks++; if (apbm_paddr !== 16'h0010) $display("FAIL err2_addr_ignored: got %h want 0010", apbm_paddr); else passes++;
    step();
    sample();
    checks++; if (apbm_psel !== 1'b0) $display("FAIL err2_no_setup: got %b want 0", apbm_psel); else passes++;
  endtask

  task automatic test_back_to_back();
    step();
    addr_phase(32'h0000_0100, 1'b1);
    apbm_pready = 1'b1;
    step();
    ahbls_htrans = 2'b00;
    ahbls_hwdata = 32'hA5A5_0001;
    sample();
    checks++; if (apbm_psel !== 1'b1 || apbm_paddr !== 16'h0100) $display("FAIL b2b_w_setup: got psel=%b paddr=%h want 1 0100", apbm_psel, apbm_paddr); else passes++;
    step();
    sample();
    checks++; if (apbm_penable !== 1'b1 || apbm_pwdata !== 32'hA5A5_0001) $display("FAIL b2b_w_access: got penable=%b pwdata=%h want 1 a5a50001", apbm_penable, apbm_pwdata); else passes++;
    step();
    addr_phase(32'h0000_0200, 1'b0);
    apbm_prdata = 32'h0BAD_CAFE;
    sample();
    checks++; if (ahbls_hready_resp !== 1'b1 || apbm_psel !== 1'b0) $display("FAIL b2b_w_done: got hready=%b psel=%b want 1 0", ahbls_hready_resp, apbm_psel); else passes++;
    step();
    ahbls_htrans = 2'b00;
    sample();
    checks++; if (apbm_psel !== 1'b1 || apbm_penable !== 1'b0 || apbm_paddr !== 16'h0200 || apbm_pwrite !== 1'b0) $display("FAIL b2b_r_setup: got psel=%b penable=%b paddr=%h pwrite=%b want 1 0 0200 0", apbm_psel, apbm_penable, apbm_paddr, apbm_pwrite); else passes++;
    step();
    sample();
    checks++; if (apbm_penable !== 1'b1 || ahbls_hready_resp !== 1'b0) $display("FAIL b2b_r_access: got penable=%b hready=%b want 1 0", apbm_penable, ahbls_hready_resp); else passes++;
    step();
    sample();
    checks++; if (ahbls_hready_resp !== 1'b1 || ahbls_hrdata !== 32'h0BAD_CAFE) $display("FAIL b2b_r_done: got hready=%b hrdata=%h want 1 0badcafe", ahbls_hready_resp, ahbls_hrdata); else passes++;
  endtask

  task automatic test_no_start();
    step();
    ahbls_htrans = 2'b01;
    ahbls_haddr  = 32'h0000_0999;
    step();
    sample();
    checks++; if (apbm_psel !== 1'b0) $display("FAIL busy_no_start: got %b want 0", apbm_psel); else passes++;
    ahbls_htrans = 2'b10;
    hready_low   = 1'b1;
    step();
    ahbls_htrans = 2'b00;
    hready_low   = 1'b0;
    sample();
    checks++; if (apbm_psel !== 1'b0 || apbm_paddr !== 16'h0200) $display("FAIL hready_low_no_start: got psel=%b paddr=%h want 0 0200", apbm_psel, apbm_paddr); else passes++;
    step();
    sample();
    checks++; if (apbm_psel !== 1'b0) $display("FAIL idle_no_start: got %b want 0", apbm_psel); else passes++;
  endtask

  task automatic test_reset_mid();
    step();
    addr_phase(32'h0000_0300, 1'b0);
    apbm_pready = 1'b0;
    step();
    ahbls_htrans = 2'b00;
    step();
    rst_n = 1'b0;
    sample();
    checks++; if (apbm_penable !== 1'b1) $display("FAIL rstmid_in_access: got %b want 1", apbm_penable); else passes++;
    step();
    rst_n = 1'b1;
    apbm_pready = 1'b1;
    sample();
    checks++; if (apbm_psel !== 1'b0 || apbm_penable !== 1'b0 || ahbls_hready_resp !== 1'b1) $display("FAIL rstmid_abort: got psel=%b penable=%b hready=%b want 0 0 1", apbm_psel, apbm_penable, ahbls_hready_resp); else passes++;
    checks++; if (ahbls_hrdata !== 32'h0 || apbm_paddr !== 16'h0000) $display("FAIL rstmid_regs: got hrdata=%h paddr=%h want 00000000 0000", ahbls_hrdata, apbm_paddr); else passes++;
    step();
    sample();
    checks++; if (apbm_psel !== 1'b0) $display("FAIL rstmid_no_resume: got %b want 0", apbm_psel); else passes++;
  endtask

  task automatic test_size();
    step();
    addr_phase(32'h0000_0403, 1'b1);
    ahbls_hsize = 3'd0;
    apbm_pready = 1'b1;
    step();
    ahbls_htrans = 2'b00;
    ahbls_hsize  = 3'd2;
    ahbls_hwdata = 32'h0000_00AB;
    sample();
`ifdef AHBL_TO_APB_SIZE_CHECK_EN
    checks++; if (apbm_psel !== 1'b0 || ahbls_hready_resp !== 1'b0 || ahbls_hresp !== 1'b1) $display("FAIL size_err1: got psel=%b hready=%b hresp=%b want 0 0 1", apbm_psel, ahbls_hready_resp, ahbls_hresp); else passes++;
    step();
    sample();
    checks++; if (apbm_psel !== 1'b0 || ahbls_hready_resp !== 1'b1 || ahbls_hresp !== 1'b1) $display("FAIL size_err2: got psel=%b hready=%b hresp=%b want 0 1 1", apbm_psel, ahbls_hready_resp, ahbls_hresp); else passes++;
    step();
    sample();
    checks++; if (apbm_psel !== 1'b0 || ahbls_hresp !== 1'b0) $display("FAIL size_idle: got psel=%b hresp=%b want 0 0", apbm_psel, ahbls_hresp); else passes++;
`else
    checks++; if (apbm_psel !== 1'b1 || apbm_paddr !== 16'h0403 || apbm_pwrite !== 1'b1) $display("FAIL size_fwd_setup: got psel=%b paddr=%h pwrite=%b want 1 0403 1", apbm_psel, apbm_paddr, apbm_pwrite); else passes++;
    step();
    sample();
    checks++; if (apbm_penable !== 1'b1 || apbm_pwdata !== 32'h0000_00AB) $display("FAIL size_fwd_access: got penable=%b pwdata=%h want 1 000000ab", apbm_penable, apbm_pwdata); else passes++;
    step();
    sample();
    checks++; if (ahbls_hready_resp !== 1'b1 || ahbls_hresp !== 1'b0) $display("FAIL size_fwd_done: got hready=%b hresp=%b want 1 0", ahbls_hready_resp, ahbls_hresp); else passes++;
`endif
  endtask

  initial begin
    rst_n           = 1'b0;
    hready_low      = 1'b0;
    ahbls_haddr     = '0;
    ahbls_hwrite    = 1'b0;
    ahbls_htrans    = 2'b00;
    ahbls_hsize     = 3'd2;
    ahbls_hburst    = 3'd0;
    ahbls_hprot     = 4'b0011;
    ahbls_hmastlock = 1'b0;
    ahbls_hwdata    = '0;
    apbm_prdata     = '0;
    apbm_pready     = 1'b1;
    apbm_pslverr    = 1'b0;

    test_reset();
    test_read();
    test_write_wait();
    test_error();
    test_back_to_back();
    test_no_start();
    test_reset_mid();
    test_size();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
